// File: rtl/sw_code_pkg.sv
// Shared constants for the slide-switch code-entry engine.
// Fill values are wide enough for every supported width; users slice them down.
package sw_code_pkg;
    localparam int MAX_CODE_W = 128;

    localparam logic [15:0]           IDX_NONE  = '1;
    localparam logic                  EVT_DOWN  = 1'b0;
    localparam logic                  EVT_UP    = 1'b1;
    localparam logic [MAX_CODE_W-1:0] CODE_INIT = '1;
endpackage

// File: rtl/sw_edge_pending.sv
// Registers the switch inputs, detects edges and keeps one pending rise/fall bit per switch.
// The scanner consumes an event via clr_en/clr_idx; an edge arriving in that cycle survives.
module sw_edge_pending #(
    parameter int N_SW  = 10,
    parameter int IDX_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_SW-1:0]   sw,
    input  logic              clr_en,
    input  logic [IDX_W-1:0]  clr_idx,
    output logic [N_SW-1:0]   pr,
    output logic [N_SW-1:0]   pf
);
    logic [N_SW-1:0] sw_q;
    logic [N_SW-1:0] sw_hist;
    logic [N_SW-1:0] rise;
    logic [N_SW-1:0] fall;
    logic [N_SW-1:0] pr_n;
    logic [N_SW-1:0] pf_n;

    assign rise = sw_q & ~sw_hist;
    assign fall = ~sw_q & sw_hist;

    // Opposite edges cancel an unconsumed event; consumption happens before the new edge lands.
    always_comb begin
        pr_n = pr;
        pf_n = pf;
        for (int i = 0; i < N_SW; i++) begin
            if (clr_en && (clr_idx == IDX_W'(i))) begin
                pr_n[i] = 1'b0;
                pf_n[i] = 1'b0;
            end
            if (rise[i]) begin
                if (pf_n[i]) pf_n[i] = 1'b0;
                else         pr_n[i] = 1'b1;
            end else if (fall[i]) begin
                if (pr_n[i]) pr_n[i] = 1'b0;
                else         pf_n[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sw_q    <= '0;
            sw_hist <= '0;
            pr      <= '0;
            pf      <= '0;
        end else begin
            sw_q    <= sw;
            sw_hist <= sw_q;
            pr      <= pr_n;
            pf      <= pf_n;
        end
    end
endmodule

// File: rtl/sw_code_entry.sv
// Slide-switch code-entry engine: round-robin scan of pending switch events,
// up/down tracking, digit accumulation into a code register with conflict/overflow flags.
module sw_code_entry
    import sw_code_pkg::*;
#(
    parameter int N_SW        = 10,
    parameter int IDX_W       = 4,
    parameter int CODE_DIGITS = 4,
    parameter int DIGIT_W     = 4
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [N_SW-1:0]                    sw,
    input  logic                               clear,
    output logic                               evt_valid,
    output logic                               evt_up,
    output logic [IDX_W-1:0]                   evt_idx,
    output logic [IDX_W:0]                     up_count,
    output logic [IDX_W-1:0]                   active_idx,
    output logic [CODE_DIGITS*DIGIT_W-1:0]     code,
    output logic [$clog2(CODE_DIGITS+1)-1:0]   code_len,
    output logic                               code_done,
    output logic                               conflict,
    output logic                               overflow
);
    localparam int CODE_W = CODE_DIGITS * DIGIT_W;
    localparam int LEN_W  = $clog2(CODE_DIGITS + 1);

    localparam logic [IDX_W-1:0]  NO_IDX    = IDX_NONE[IDX_W-1:0];
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SW - 1);
    localparam logic [IDX_W:0]    MAX_UP    = (IDX_W+1)'(N_SW);
    localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(CODE_DIGITS);
    localparam logic [CODE_W-1:0] CODE_FILL = CODE_INIT[CODE_W-1:0];

    logic [N_SW-1:0]  pr;
    logic [N_SW-1:0]  pf;
    logic [IDX_W-1:0] k;
    logic             hit;

    logic              evt_valid_n;
    logic              evt_up_n;
    logic [IDX_W-1:0]  evt_idx_n;
    logic [IDX_W:0]    up_count_n;
    logic [IDX_W-1:0]  active_n;
    logic [CODE_W-1:0] code_n;
    logic [LEN_W-1:0]  len_n;
    logic              done_n;
    logic              conflict_n;
    logic              overflow_n;
    logic [IDX_W-1:0]  k_n;

    sw_edge_pending #(
        .N_SW  (N_SW),
        .IDX_W (IDX_W)
    ) u_pending (
        .clk     (clk),
        .reset_n (reset_n),
        .sw      (sw),
        .clr_en  (hit),
        .clr_idx (k),
        .pr      (pr),
        .pf      (pf)
    );

    assign hit = pr[k] | pf[k];

    // Clear is applied to the code state first so an event in the same cycle lands as digit one.
    always_comb begin
        k_n         = (k == LAST_IDX) ? '0 : k + IDX_W'(1);
        evt_valid_n = hit;
        evt_up_n    = evt_up;
        evt_idx_n   = NO_IDX;
        up_count_n  = up_count;
        active_n    = active_idx;
        code_n      = clear ? CODE_FILL : code;
        len_n       = clear ? '0 : code_len;
        done_n      = 1'b0;
        conflict_n  = clear ? 1'b0 : conflict;
        overflow_n  = clear ? 1'b0 : overflow;

        if (hit) begin
            evt_idx_n = k;
            if (pr[k]) begin
                evt_up_n = EVT_UP;
                if (up_count != MAX_UP) up_count_n = up_count + (IDX_W+1)'(1);
                if (up_count == '0) begin
                    active_n = k;
                    if (len_n < FULL_LEN) begin
                        code_n = (code_n << DIGIT_W) | CODE_W'(k);
                        len_n  = len_n + LEN_W'(1);
                        done_n = (len_n == FULL_LEN);
                    end else begin
                        overflow_n = 1'b1;
                    end
                end else begin
                    conflict_n = 1'b1;
                end
            end else begin
                evt_up_n = EVT_DOWN;
                if (up_count != '0) up_count_n = up_count - (IDX_W+1)'(1);
                // Losing the first-raised switch leaves no meaningful active index.
                if ((up_count_n == '0) || (k == active_idx)) active_n = NO_IDX;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            k          <= '0;
            evt_valid  <= 1'b0;
            evt_up     <= 1'b0;
            evt_idx    <= NO_IDX;
            up_count   <= '0;
            active_idx <= NO_IDX;
            code       <= CODE_FILL;
            code_len   <= '0;
            code_done  <= 1'b0;
            conflict   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            k          <= k_n;
            evt_valid  <= evt_valid_n;
            evt_up     <= evt_up_n;
            evt_idx    <= evt_idx_n;
            up_count   <= up_count_n;
            active_idx <= active_n;
            code       <= code_n;
            code_len   <= len_n;
            code_done  <= done_n;
            conflict   <= conflict_n;
            overflow   <= overflow_n;
        end
    end
endmodule

// File: tb/tb_sw_code_entry.sv
// Directed self-checking bench for sw_code_entry with default parameters (10 switches, 4x4-bit code).
// Inputs change just after a falling edge; outputs are sampled on falling edges.
module tb_sw_code_entry;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  sw;
    logic        clear;
    logic        evt_valid;
    logic        evt_up;
    logic [3:0]  evt_idx;
    logic [4:0]  up_count;
    logic [3:0]  active_idx;
    logic [15:0] code;
    logic [2:0]  code_len;
    logic        code_done;
    logic        conflict;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    int evt_count;
    int done_count;
    int scan_count = 0;
    logic [3:0] last_idx;
    logic       last_up;

    sw_code_entry dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sw         (sw),
        .clear      (clear),
        .evt_valid  (evt_valid),
        .evt_up     (evt_up),
        .evt_idx    (evt_idx),
        .up_count   (up_count),
        .active_idx (active_idx),
        .code       (code),
        .code_len   (code_len),
        .code_done  (code_done),
        .conflict   (conflict),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Independent count of scan steps since reset; its value mod 10 is the switch scanned this cycle.
    always @(posedge clk) begin
        if (!reset_n) scan_count <= 0;
        else          scan_count <= scan_count + 1;
    end

    task automatic applyStimulus(input logic [9:0] s, input logic c, input logic r);
        sw      = s;
        clear   = c;
        reset_n = r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic runCycles(input int n);
        evt_count  = 0;
        done_count = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (evt_valid) begin
                evt_count++;
                last_idx = evt_idx;
                last_up  = evt_up;
            end
            if (code_done) done_count++;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_evt_valid"}, 32'(evt_valid), 32'h0);
        checkOutput({tag, "_evt_idx"},   32'(evt_idx),   32'hF);
        checkOutput({tag, "_up_count"},  32'(up_count),  32'h0);
        checkOutput({tag, "_active"},    32'(active_idx), 32'hF);
        checkOutput({tag, "_code"},      32'(code),      32'hFFFF);
        checkOutput({tag, "_code_len"},  32'(code_len),  32'h0);
        checkOutput({tag, "_flags"},     32'({code_done, conflict, overflow}), 32'h0);
    endtask

    initial begin
        int digits[4] = '{3, 7, 0, 9};
        int total_done;
        logic [9:0] s;

        $display("[TB] start");
        applyStimulus(10'h000, 1'b0, 1'b0);
        runCycles(2);
        checkResetState("reset");

        // Quiet switches: nothing happens.
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(20);
        checkOutput("idle_events", 32'(evt_count), 32'd0);
        checkOutput("idle_code", 32'(code), 32'hFFFF);
        checkOutput("idle_up_count", 32'(up_count), 32'd0);

        // Enter 3,7,0,9 one switch at a time.
        total_done = 0;
        for (int d = 0; d < 4; d++) begin
            s = 10'h000;
            s[digits[d]] = 1'b1;
            applyStimulus(s, 1'b0, 1'b1);
            runCycles(14);
            total_done += done_count;
            checkOutput($sformatf("digit%0d_events", d), 32'(evt_count), 32'd1);
            checkOutput($sformatf("digit%0d_idx", d), 32'(last_idx), 32'(digits[d]));
            checkOutput($sformatf("digit%0d_up", d), 32'(last_up), 32'd1);
            checkOutput($sformatf("digit%0d_active", d), 32'(active_idx), 32'(digits[d]));
            checkOutput($sformatf("digit%0d_len", d), 32'(code_len), 32'(d + 1));
            applyStimulus(10'h000, 1'b0, 1'b1);
            runCycles(14);
            total_done += done_count;
            checkOutput($sformatf("digit%0d_down", d), 32'(last_up), 32'd0);
            checkOutput($sformatf("digit%0d_up_count", d), 32'(up_count), 32'd0);
            checkOutput($sformatf("digit%0d_active_idle", d), 32'(active_idx), 32'hF);
        end
        checkOutput("code_3709", 32'(code), 32'h3709);
        checkOutput("code_len_full", 32'(code_len), 32'd4);
        checkOutput("code_done_pulses", 32'(total_done), 32'd1);
        checkOutput("no_conflict", 32'(conflict), 32'd0);
        checkOutput("evt_idx_idle", 32'(evt_idx), 32'hF);

        // Fifth digit with a full code.
        applyStimulus(10'h020, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("ovf_flag", 32'(overflow), 32'd1);
        checkOutput("ovf_code", 32'(code), 32'h3709);
        checkOutput("ovf_len", 32'(code_len), 32'd4);
        checkOutput("ovf_no_done", 32'(done_count), 32'd0);
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(14);
        applyStimulus(10'h000, 1'b1, 1'b1);
        runCycles(1);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("clear_code", 32'(code), 32'hFFFF);
        checkOutput("clear_len", 32'(code_len), 32'd0);
        checkOutput("clear_ovf", 32'(overflow), 32'd0);

        // Two switches up: second one is a conflict, not a digit.
        applyStimulus(10'h004, 1'b0, 1'b1);
        runCycles(14);
        applyStimulus(10'h024, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("conf_up_count", 32'(up_count), 32'd2);
        checkOutput("conf_active", 32'(active_idx), 32'd2);
        checkOutput("conf_flag", 32'(conflict), 32'd1);
        checkOutput("conf_code", 32'(code), 32'hFFF2);
        checkOutput("conf_len", 32'(code_len), 32'd1);
        applyStimulus(10'h004, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("conf_drop5_count", 32'(up_count), 32'd1);
        checkOutput("conf_drop5_active", 32'(active_idx), 32'd2);
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("conf_drop2_count", 32'(up_count), 32'd0);
        checkOutput("conf_drop2_active", 32'(active_idx), 32'hF);
        checkOutput("conf_sticky", 32'(conflict), 32'd1);
        applyStimulus(10'h000, 1'b1, 1'b1);
        runCycles(1);
        applyStimulus(10'h000, 1'b0, 1'b1);
        checkOutput("clear_conflict", 32'(conflict), 32'd0);

        // One-cycle pulse on SW[4], timed so the scanner is elsewhere while PR[4] exists.
        for (int i = 0; i < 20 && (scan_count % 10) != 8; i++) runCycles(1);
        applyStimulus(10'h010, 1'b0, 1'b1);
        runCycles(1);
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("pulse_events", 32'(evt_count), 32'd0);
        checkOutput("pulse_up_count", 32'(up_count), 32'd0);
        checkOutput("pulse_code", 32'(code), 32'hFFFF);

        // Two digits, then a pending event discarded by reset.
        applyStimulus(10'h002, 1'b0, 1'b1);
        runCycles(14);
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(14);
        applyStimulus(10'h040, 1'b0, 1'b1);
        runCycles(14);
        applyStimulus(10'h000, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("pre_reset_code", 32'(code), 32'hFF16);
        checkOutput("pre_reset_len", 32'(code_len), 32'd2);
        applyStimulus(10'h100, 1'b0, 1'b1);
        runCycles(2);
        applyStimulus(10'h100, 1'b0, 1'b0);
        runCycles(1);
        checkResetState("mid_reset");
        applyStimulus(10'h100, 1'b0, 1'b1);
        runCycles(14);
        checkOutput("post_reset_events", 32'(evt_count), 32'd1);
        checkOutput("post_reset_up_count", 32'(up_count), 32'd1);
        checkOutput("post_reset_active", 32'(active_idx), 32'd8);
        checkOutput("post_reset_code", 32'(code), 32'hFFF8);
        checkOutput("post_reset_len", 32'(code_len), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
